// File: rtl/pwm_pkg.sv
// Shared widths, per-channel lane record and the phase-wrapped local count helper
// for the multiphase complementary PWM.
package pwm_pkg;

    localparam int PWM_CNT_W  = 12;
    localparam int PWM_DT_W   = 8;
    // Lane fields are sized for the widest supported counter; narrower counters zero-extend.
    localparam int PWM_LANE_W = 16;

    typedef struct packed {
        logic [PWM_LANE_W-1:0] duty;
        logic [PWM_LANE_W-1:0] phase;
    } pwm_lane_t;

    // Local count of a channel: cnt advanced by its phase, wrapped into [0, eff_per).
    // A phase that does not fit inside the period behaves as no phase at all.
    function automatic logic [PWM_LANE_W-1:0] local_count(
        input logic [PWM_LANE_W-1:0] cnt,
        input logic [PWM_LANE_W-1:0] phase,
        input logic [PWM_LANE_W-1:0] eff_per
    );
        logic [PWM_LANE_W:0]   sum;
        logic [PWM_LANE_W-1:0] ph;
        ph  = (phase >= eff_per) ? '0 : phase;
        sum = {1'b0, cnt} + {1'b0, ph};
        if (sum >= {1'b0, eff_per}) begin
            sum = sum - {1'b0, eff_per};
        end
        return sum[PWM_LANE_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_deadband.sv
// One complementary output pair: tracks how long raw has been stable and only
// drives a gate once that stable time reaches the dead time.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int DT_W = PWM_DT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            raw,
    input  logic            kill,
    input  logic [DT_W-1:0] dt,
    output logic            pwm_hi,
    output logic            pwm_lo
);

    logic            raw_q;
    logic [DT_W-1:0] dtc_q;
    logic [DT_W-1:0] dtc;
    logic            settled;

    // Any edge on raw restarts the stable-time count in the same cycle.
    assign dtc     = (raw != raw_q) ? '0 : dtc_q;
    assign settled = (dtc >= dt) && !kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q  <= 1'b0;
            dtc_q  <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else if (clr) begin
            raw_q  <= 1'b0;
            dtc_q  <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            raw_q  <= raw;
            dtc_q  <= (&dtc) ? dtc : dtc + DT_W'(1);
            pwm_hi <= raw & settled;
            pwm_lo <= ~raw & settled;
        end
    end

endmodule

// File: rtl/pwm_multiphase_dt.sv
// N-channel complementary PWM with per-channel duty/phase, dead band, shadowed
// updates applied at period wrap, latched fault shutdown and an ADC trigger strobe.
module pwm_multiphase_dt
    import pwm_pkg::*;
#(
    parameter int CH      = 2,
    parameter int CNT_W   = PWM_CNT_W,
    parameter int DT_W    = PWM_DT_W,
    parameter int PER_RST = 800,
    parameter int DT_RST  = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CNT_W-1:0]    period,
    input  logic [CH*CNT_W-1:0] duty,
    input  logic [CH*CNT_W-1:0] phase,
    input  logic [DT_W-1:0]     dead_time,
    input  logic [CNT_W-1:0]    trig_pt,
    input  logic                upd,
    output logic                upd_pend,
    output logic                upd_done,
    input  logic                fault,
    input  logic                fault_clr,
    output logic                faulted,
    output logic [CH-1:0]       pwm_hi,
    output logic [CH-1:0]       pwm_lo,
    output logic                adc_trig
);

    localparam logic [CNT_W-1:0] PER_RST_V = CNT_W'(PER_RST);
    localparam logic [DT_W-1:0]  DT_RST_V  = DT_W'(DT_RST);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_per;
    logic             wrap;
    logic             load_act;
    logic             kill;
    logic             out_block;

    logic [CNT_W-1:0] per_a, per_s;
    logic [CNT_W-1:0] trig_a, trig_s;
    logic [DT_W-1:0]  dt_a, dt_s;
    pwm_lane_t        lane_a [CH];
    pwm_lane_t        lane_s [CH];

    assign eff_per  = (per_a < CNT_W'(2)) ? CNT_W'(2) : per_a;
    assign wrap     = en && (cnt == eff_per - CNT_W'(1));
    assign load_act = !en || wrap;
    // The fault input gates outputs combinationally so the edge that latches it already drives 0.
    assign kill     = fault || faulted || out_block;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load_act) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Update handshake: upd is a single-cycle strobe that is always accepted (no back-pressure);
    // it writes the shadow bank and raises upd_pend. upd_pend stays high until the next wrap
    // copies shadow to active, and upd_done pulses for exactly one cycle after that copy.
    // An upd landing on the wrap cycle itself is held for the following wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_a  <= PER_RST_V;
            per_s  <= PER_RST_V;
            dt_a   <= DT_RST_V;
            dt_s   <= DT_RST_V;
            trig_a <= '0;
            trig_s <= '0;
            for (int k = 0; k < CH; k++) begin
                lane_a[k] <= '0;
                lane_s[k] <= '0;
            end
        end else begin
            if (load_act) begin
                per_a  <= per_s;
                dt_a   <= dt_s;
                trig_a <= trig_s;
                for (int k = 0; k < CH; k++) begin
                    lane_a[k] <= lane_s[k];
                end
            end
            if (upd) begin
                per_s  <= period;
                dt_s   <= dead_time;
                trig_s <= trig_pt;
                for (int k = 0; k < CH; k++) begin
                    lane_s[k].duty  <= PWM_LANE_W'(duty[k*CNT_W +: CNT_W]);
                    lane_s[k].phase <= PWM_LANE_W'(phase[k*CNT_W +: CNT_W]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_pend <= 1'b0;
            upd_done <= 1'b0;
        end else begin
            upd_done <= wrap && upd_pend;
            if (!en) begin
                upd_pend <= 1'b0;
            end else if (upd) begin
                upd_pend <= 1'b1;
            end else if (wrap) begin
                upd_pend <= 1'b0;
            end
        end
    end

    // After fault_clr the outputs stay parked until a wrap seen with the latch already clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            faulted   <= 1'b0;
            out_block <= 1'b0;
        end else begin
            if (fault) begin
                faulted <= 1'b1;
            end else if (fault_clr) begin
                faulted <= 1'b0;
            end
            if (fault) begin
                out_block <= 1'b1;
            end else if (wrap && !faulted) begin
                out_block <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_trig <= 1'b0;
        end else begin
            adc_trig <= en && (cnt == trig_a) && (trig_a < eff_per);
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [PWM_LANE_W-1:0] lc;
        logic                  raw;

        assign lc  = local_count(PWM_LANE_W'(cnt), lane_a[k].phase, PWM_LANE_W'(eff_per));
        assign raw = (lc < lane_a[k].duty);

        pwm_deadband #(
            .DT_W (DT_W)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (!en),
            .raw    (raw),
            .kill   (kill),
            .dt     (dt_a),
            .pwm_hi (pwm_hi[k]),
            .pwm_lo (pwm_lo[k])
        );
    end

endmodule
